// File: rtl/cache_ctrl.sv
// Lookup/refill sequencer for the set-associative cache array, including the cache_pkg types.
// Optional hit/miss counters are enabled by defining CACHE_CTRL_STATS_EN.
package cache_pkg;
    localparam int unsigned SetWidth      = 4;
    localparam int unsigned TagWidth      = 8;
    localparam int unsigned Associativity = 4;
    localparam int unsigned DataWidth     = 8;

    typedef struct packed {
        logic                valid;
        logic [TagWidth-1:0] tag;
    } block_info_t;

    typedef logic [DataWidth-1:0] block_data_t;
endpackage

module cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned SetWidth      = cache_pkg::SetWidth,
    parameter int unsigned TagWidth      = cache_pkg::TagWidth,
    parameter int unsigned Associativity = cache_pkg::Associativity,
    parameter int unsigned DataWidth     = cache_pkg::DataWidth
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [SetWidth-1:0]                   req_set_i,
    input  logic [TagWidth-1:0]                   req_tag_i,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output logic [DataWidth-1:0]                  resp_data_o,
    output logic                                  resp_hit_o,
    output logic [SetWidth-1:0]                   cache_read_set_o,
    output logic [TagWidth-1:0]                   cache_read_tag_o,
    input  logic                                  cache_hit_i,
    input  block_info_t [Associativity-1:0]       cache_set_info_i,
    input  block_data_t [Associativity-1:0]       cache_set_data_i,
    output logic                                  cache_write_en_o,
    output logic [SetWidth-1:0]                   cache_write_set_o,
    output block_info_t [Associativity-1:0]       cache_write_info_o,
    output block_data_t [Associativity-1:0]       cache_write_data_o,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output logic [SetWidth-1:0]                   mem_req_set_o,
    output logic [TagWidth-1:0]                   mem_req_tag_o,
    input  logic                                  mem_rsp_valid_i,
    input  logic [DataWidth-1:0]                  mem_rsp_data_i
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                           hit_count_o,
    output logic [31:0]                           miss_count_o
`endif
);

    localparam int unsigned WayWidth = (Associativity > 1) ? $clog2(Associativity) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        INSTALL  = 3'd4,
        RESP     = 3'd5
    } state_e;

    state_e                            state_q;
    logic [SetWidth-1:0]               set_q;
    logic [TagWidth-1:0]               tag_q;
    logic                              req_ready_q;
    logic                              resp_valid_q;
    logic [DataWidth-1:0]              resp_data_q;
    logic                              resp_hit_q;
    logic                              mem_req_valid_q;
    logic                              wr_en_q;
    block_info_t [Associativity-1:0]   wr_info_q;
    block_data_t [Associativity-1:0]   wr_data_q;
    logic [WayWidth-1:0]               victim_q;

    logic                              hit_found_c;
    logic [WayWidth-1:0]               hit_way_c;
    logic                              inv_found_c;
    logic [WayWidth-1:0]               inv_way_c;
    logic [WayWidth-1:0]               victim_way_c;
    block_info_t [Associativity-1:0]   wr_info_c;
    block_data_t [Associativity-1:0]   wr_data_c;

    // Lowest matching way for hit data, lowest invalid way for refill placement
    always_comb begin
        hit_found_c = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        for (int unsigned i = 0; i < Associativity; i++) begin
            if (!hit_found_c && cache_set_info_i[i].valid && cache_set_info_i[i].tag == tag_q) begin
                hit_found_c = 1'b1;
                hit_way_c   = WayWidth'(i);
            end
            if (!inv_found_c && !cache_set_info_i[i].valid) begin
                inv_found_c = 1'b1;
                inv_way_c   = WayWidth'(i);
            end
        end
        victim_way_c = inv_found_c ? inv_way_c : victim_q;
        wr_info_c    = cache_set_info_i;
        wr_data_c    = cache_set_data_i;
        wr_info_c[victim_way_c] = '{valid: 1'b1, tag: tag_q};
        wr_data_c[victim_way_c] = mem_rsp_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            set_q           <= '0;
            tag_q           <= '0;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_hit_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_info_q       <= '0;
            wr_data_q       <= '0;
            victim_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        set_q       <= req_set_i;
                        tag_q       <= req_tag_i;
                        req_ready_q <= 1'b0;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cache_hit_i) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= cache_set_data_i[hit_way_c];
                        resp_hit_q   <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        state_q         <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        resp_data_q <= mem_rsp_data_i;
                        wr_en_q     <= 1'b1;
                        wr_info_q   <= wr_info_c;
                        wr_data_q   <= wr_data_c;
                        // Round-robin only advances when a valid way is evicted
                        if (!inv_found_c) begin
                            victim_q <= (victim_q == WayWidth'(Associativity - 1)) ? '0 : victim_q + 1'b1;
                        end
                        state_q <= INSTALL;
                    end
                end
                INSTALL: begin
                    wr_en_q      <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= 1'b0;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating lookup outcome counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (cache_hit_i) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

    assign req_ready_o        = req_ready_q;
    assign resp_valid_o       = resp_valid_q;
    assign resp_data_o        = resp_data_q;
    assign resp_hit_o         = resp_hit_q;
    assign cache_read_set_o   = set_q;
    assign cache_read_tag_o   = tag_q;
    assign cache_write_en_o   = wr_en_q;
    assign cache_write_set_o  = set_q;
    assign cache_write_info_o = wr_info_q;
    assign cache_write_data_o = wr_data_q;
    assign mem_req_valid_o    = mem_req_valid_q;
    assign mem_req_set_o      = set_q;
    assign mem_req_tag_o      = tag_q;

endmodule
